// File: rtl/pet_need_ctrl_pkg.sv
// Shared state and channel codes for the virtual-pet controller and face-matrix driver.
package pet_defs;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ALERT = 2'd1,
        ST_ACK   = 2'd2,
        ST_SAD   = 2'd3
    } pet_state_e;

    localparam logic [2:0] CH_HUNGER = 3'd0;
    localparam logic [2:0] CH_SLEEP  = 3'd1;
    localparam logic [2:0] CH_PLAY   = 3'd2;

    // Lowest set bit wins: hunger outranks sleep outranks play.
    function automatic logic [2:0] lowest_set(input logic [7:0] v);
        logic [2:0] r;
        r = '0;
        for (int i = 7; i >= 0; i--)
            if (v[i]) r = 3'(i);
        return r;
    endfunction

endpackage

// File: rtl/pet_need_ctrl_timer.sv
// Per-channel need timer: counts seconds while the need is not pending, flags expiry.
module need_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             clr,
    input  logic [CNT_W-1:0] limit,
    output logic             expire
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;

    assign cnt_inc = cnt + 1'b1;
    assign expire  = tick && !clr && (cnt_inc == limit);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (clr || expire)
            cnt <= '0;
        else if (tick)
            cnt <= cnt_inc;
    end

endmodule

// File: rtl/pet_need_ctrl.sv
// Virtual-pet behaviour controller: need timers, priority alert, service wait and timed acknowledge.
module pet_need_ctrl
    import pet_defs::*;
#(
    parameter int CLK_HZ    = 50_000_000,
    parameter int N_NEEDS   = 3,
    parameter int TIMEOUT_S = 60,
    parameter int NEGLECT_S = 30,
    parameter int ACK_S     = 3,
    parameter int NEAR_CM   = 5,
    parameter int CM_W      = 16,
    parameter int TIME_W    = 12
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [CM_W-1:0]    dist_cm,
    input  logic               dist_valid,
    input  logic [N_NEEDS-1:0] btn,
    output logic [1:0]         state,
    output logic [2:0]         cur_ch,
    output logic [N_NEEDS-1:0] pending,
    output logic [TIME_W-1:0]  secs,
    output logic [7:0]         miss_cnt,
    output logic               tick
);

    localparam int DIV_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int LIM_W = $clog2(TIMEOUT_S * N_NEEDS + 1);
    localparam logic [DIV_W-1:0]  DIV_MAX   = DIV_W'(CLK_HZ - 1);
    localparam logic [TIME_W-1:0] NEG_LAST  = TIME_W'(NEGLECT_S - 1);
    localparam logic [TIME_W-1:0] ACK_LAST  = TIME_W'(ACK_S - 1);
    localparam logic [CM_W-1:0]   NEAR_LIM  = CM_W'(NEAR_CM);

    pet_state_e         st;
    logic [DIV_W-1:0]   div;
    logic [N_NEEDS-1:0] expire;
    logic [N_NEEDS-1:0] btn_d1, btn_d2;
    logic [7:0]         rise8, pend8, ack_clr8;
    logic               prox, svc, neglect, ack_done, leave;

    assign state = st;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div  <= '0;
            tick <= 1'b0;
        end else begin
            tick <= (div == DIV_MAX);
            div  <= (div == DIV_MAX) ? '0 : div + 1'b1;
        end
    end

    for (genvar g = 0; g < N_NEEDS; g++) begin : g_tmr
        need_timer #(.CNT_W(LIM_W)) u_tmr (
            .clk    (clk),
            .reset  (reset),
            .tick   (tick),
            .clr    (pending[g]),
            .limit  (LIM_W'(TIMEOUT_S * (g + 1))),
            .expire (expire[g])
        );
    end

    // Buttons pass one sample stage before edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_d1 <= '0;
            btn_d2 <= '0;
        end else begin
            btn_d1 <= btn;
            btn_d2 <= btn_d1;
        end
    end

    always_comb begin
        rise8 = '0;
        rise8[N_NEEDS-1:0] = btn_d1 & ~btn_d2;
        pend8 = '0;
        pend8[N_NEEDS-1:0] = pending;
    end

    assign prox     = dist_valid && (dist_cm <= NEAR_LIM);
    assign svc      = ((st == ST_ALERT) || (st == ST_SAD)) &&
                      ((cur_ch == CH_HUNGER) ? prox : rise8[cur_ch]);
    assign neglect  = (st == ST_ALERT) && tick && (secs == NEG_LAST);
    assign ack_done = (st == ST_ACK) && tick && (secs == ACK_LAST);
    assign ack_clr8 = ack_done ? (8'd1 << cur_ch) : 8'd0;
    assign leave    = ((st == ST_IDLE) && (|pending)) || svc || neglect || ack_done;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st       <= ST_IDLE;
            cur_ch   <= '0;
            secs     <= '0;
            miss_cnt <= '0;
            pending  <= '0;
        end else begin
            pending <= (pending | expire) & ~ack_clr8[N_NEEDS-1:0];

            if (leave)
                secs <= '0;
            else if (tick && (secs != '1))
                secs <= secs + 1'b1;

            case (st)
                ST_IDLE:
                    if (|pending) begin
                        st     <= ST_ALERT;
                        cur_ch <= lowest_set(pend8);
                    end
                // Service takes precedence over a neglect expiry on the same cycle.
                ST_ALERT:
                    if (svc)
                        st <= ST_ACK;
                    else if (neglect) begin
                        st <= ST_SAD;
                        if (miss_cnt != 8'hFF)
                            miss_cnt <= miss_cnt + 1'b1;
                    end
                ST_SAD:
                    if (svc)
                        st <= ST_ACK;
                ST_ACK:
                    if (ack_done)
                        st <= ST_IDLE;
                default:
                    st <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/pet_need_ctrl.md
# pet_need_ctrl

Parametrised behaviour controller for the virtual-pet design. It runs N independent need timers (channel 0 = hunger, then sleep, play, …) off a 1 Hz tick derived from `clk`, and raises the highest-priority expired need. It waits for that need to be serviced (proximity for channel 0, a button for the others) and then runs a timed acknowledge phase. Its outputs drive the seven-segment status display and the face-matrix driver; its distance input comes from the ultrasonic ranger.

## Interface
- `CLK_HZ`, default 50_000_000: clock cycles per 1 s tick.
- `N_NEEDS`, default 3: number of need channels, 1..8.
- `TIMEOUT_S`, default 60: base timeout; channel i expires after TIMEOUT_S*(i+1) s.
- `NEGLECT_S`, default 30: seconds in ALERT before entering SAD.
- `ACK_S`, default 3: seconds spent in ACK.
- `NEAR_CM`, default 5: proximity threshold, inclusive.
- `CM_W`, default 16: distance width.
- `TIME_W`, default 12: seconds-counter width.
- `clk`  in  1  system clock.
- `reset`  in  1  reset, asynchronous, active-high.
- `dist_cm`  in  CM_W  latest distance from the ranger, in cm.
- `dist_valid`  in  1  `dist_cm` is a fresh measurement this cycle.
- `btn`  in  N_NEEDS  synchronised, debounced, level buttons; bit i services channel i (i ≥ 1; bit 0 unused).
- `state`  out  2  0 IDLE, 1 ALERT, 2 ACK, 3 SAD.
- `cur_ch`  out  3  channel being alerted or acknowledged.
- `pending`  out  N_NEEDS  expired, unserviced needs.
- `secs`  out  TIME_W  seconds elapsed in the current state.
- `miss_cnt`  out  8  count of ALERT→SAD transitions, saturating at 255.
- `tick`  out  1  one-cycle pulse, once per second.

## Operation
- **Divider:** counts 0..CLK_HZ-1. `tick`=1 on the cycle it wraps to 0, giving exactly one pulse per CLK_HZ cycles.
- **Channel timer i:** increments on `tick` while `pending[i]`=0.
  - On reaching TIMEOUT_S*(i+1) it sets `pending[i]` and clears.
  - It holds at 0 while `pending[i]`=1.
- **Service event:**
  - Channel 0: `dist_valid` && `dist_cm` ≤ NEAR_CM.
  - Channel i ≥ 1: rising edge of `btn[i]`.
  - Only the event for `cur_ch` counts, and only in ALERT or SAD. Events at any other time are ignored.
  - Exactly one service is accepted per alert, so holding the pet near or holding a button does nothing extra.
- **FSM:**
  - IDLE: if `pending`≠0, go to ALERT with `cur_ch` = lowest set index.
  - ALERT: on service go to ACK. Otherwise, when `secs` reaches NEGLECT_S, go to SAD and increment `miss_cnt`.
  - SAD: on service go to ACK. No timeout.
  - ACK: when `secs` reaches ACK_S, clear `pending[cur_ch]` and go to IDLE.
- **`secs`:** cleared on every state change, otherwise incremented on `tick`, saturating at all ones.
- `cur_ch` is latched on entry to ALERT and holds through SAD and ACK. A higher-priority need expiring meanwhile does not pre-empt.
- **Simultaneous events:**
  - Service on the same cycle as the neglect expiry: service wins, go to ACK, no miss.
  - `pending` clear and a new expiry on the same cycle touch different channels, so no conflict.
  - Expiry of another channel during ACK is served from IDLE on the following cycle.
- **Reset** (any time, including mid-ACK): all counters, `pending` and `miss_cnt` go to 0, `state`=IDLE, `cur_ch`=0, `tick`=0.

## Timing
- Service to `state`=ACK: 1 cycle (registered).
- Expiry: the `tick` cycle sets `pending` on the next edge. IDLE→ALERT follows one cycle later.
- ACK lasts ACK_S ticks after entry; the first tick after entry counts as 1.
- `btn` edge detection uses one internal register stage, adding 1 cycle of latency versus proximity.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- Shared package/header `pet_defs`:
  - state codes `ST_IDLE`/`ST_ALERT`/`ST_ACK`/`ST_SAD`;
  - channel indices `CH_HUNGER=0`, `CH_SLEEP=1`, `CH_PLAY=2`.
  - The face-matrix driver uses the same codes.
- One sub-module, `need_timer`, instantiated N_NEEDS times through a generate loop.
  - Inputs: `tick`, `clr`, `limit`. Outputs: `expire`.
  - It holds the per-channel counter.
- The divider, priority encoder, edge detectors and FSM live in the top level.

## Test plan
- **Tick and expiry:** CLK_HZ=10, TIMEOUT_S=4, N_NEEDS=3. `tick` occurs every 10 cycles. `pending`=001 after 4 ticks, 011 after 8, 111 after 12. `state`=ALERT with `cur_ch`=0 one cycle after the first expiry.
- **Proximity service:** in ALERT ch0, `dist_cm`=6 with `dist_valid` → no change; then `dist_cm`=5 → ACK next cycle. After ACK_S=3 ticks, `pending[0]`=0 and `state` returns to IDLE, then immediately ALERT with `cur_ch`=1.
- **Button service:** `btn[2]` pulse during ALERT ch1 → ignored. `btn[1]` rising edge → ACK. A `btn[1]` held high through ACK causes no second service.
- **Neglect:** NEGLECT_S=5, no service → SAD after 5 ticks and `miss_cnt`=1. Service in SAD → ACK. Service arriving on the same cycle as the 5th tick → ACK, `miss_cnt` unchanged.
- **Saturation:** force 256 neglects → `miss_cnt` stays 255. `secs` saturates in SAD with TIME_W=4.
- **Reset mid-ACK:** assert `reset` asynchronously between clock edges → all outputs 0 immediately. After release, timers restart from 0 and the first expiry occurs after exactly TIMEOUT_S ticks.
